// File: rtl/rv_dmem_lsu.sv
// Load/store unit: runs one execute request as a single pipelined-Wishbone data cycle,
// aligns store data/byte selects, and returns the raw load word with done/error strobes.
module rv_dmem_lsu #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        x_valid_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [2:0]  x_fun_i,
  input  logic [31:0] x_addr_i,
  input  logic [31:0] x_store_data_i,
  output logic        busy_o,
  output logic        dm_load_done_o,
  output logic        dm_store_done_o,
  output logic [31:0] dm_data_l_o,
  output logic        dm_misaligned_o,
  output logic        dm_bus_err_o,
  output logic        dm_cyc_o,
  output logic        dm_stb_o,
  output logic        dm_we_o,
  output logic [31:0] dm_adr_o,
  output logic [3:0]  dm_sel_o,
  output logic [31:0] dm_dat_o,
  input  logic [31:0] dm_dat_i,
  input  logic        dm_ack_i,
  input  logic        dm_stall_i
);

  // Width codes follow the RISC-V load/store funct3 encoding.
  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_L  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_STROBE,
    S_WAIT_ACK
  } state_e;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        load_q, load_d;
  logic        we_q, we_d;
  logic [31:0] adr_q, adr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] dat_q, dat_d;
  logic [31:0] data_l_q, data_l_d;
  logic        load_done_q, load_done_d;
  logic        store_done_q, store_done_d;
  logic        misal_q, misal_d;
  logic        err_q, err_d;

  logic        is_half, is_word, misaligned;
  logic        accept, ack_end, expired;
  logic [3:0]  req_sel;
  logic [31:0] req_dat;

  assign is_half    = (x_fun_i == LDST_H) || (x_fun_i == LDST_HU);
  assign is_word    = (x_fun_i == LDST_L);
  assign misaligned = (is_half && x_addr_i[0]) || (is_word && (x_addr_i[1:0] != 2'b00));

  // The done-pulse cycle still counts as busy, so a new request lands the cycle after.
  assign busy_o  = (state_q != S_IDLE) || load_done_q || store_done_q;
  assign accept  = (state_q == S_IDLE) && !busy_o && x_valid_i && (x_load_i || x_store_i);

  // An ack only counts once the strobe has actually been taken by the slave.
  assign ack_end = dm_ack_i && ((state_q == S_WAIT_ACK) || !dm_stall_i);
  assign expired = (cnt_q == CNT_MAX) && !ack_end;

  always_comb begin
    req_sel = 4'b1111;
    req_dat = 32'h0;
    if (x_store_i) begin
      case (x_fun_i)
        LDST_B, LDST_BU: begin
          req_sel = 4'b0001 << x_addr_i[1:0];
          req_dat = {4{x_store_data_i[7:0]}};
        end
        LDST_H, LDST_HU: begin
          req_sel = x_addr_i[1] ? 4'b1100 : 4'b0011;
          req_dat = {2{x_store_data_i[15:0]}};
        end
        default: begin
          req_sel = 4'b1111;
          req_dat = x_store_data_i;
        end
      endcase
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    load_d       = load_q;
    we_d         = we_q;
    adr_d        = adr_q;
    sel_d        = sel_q;
    dat_d        = dat_q;
    data_l_d     = data_l_q;
    load_done_d  = 1'b0;
    store_done_d = 1'b0;
    misal_d      = 1'b0;
    err_d        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          adr_d  = {x_addr_i[31:2], 2'b00};
          sel_d  = req_sel;
          dat_d  = req_dat;
          we_d   = x_store_i;
          load_d = x_load_i;
          cnt_d  = '0;
          if (misaligned) begin
            load_done_d  = x_load_i;
            store_done_d = x_store_i;
            misal_d      = 1'b1;
          end else begin
            state_d = S_STROBE;
          end
        end
      end

      S_STROBE, S_WAIT_ACK: begin
        cnt_d = cnt_q + CW'(1);
        if (ack_end) begin
          state_d      = S_IDLE;
          load_done_d  = load_q;
          store_done_d = !load_q;
          if (load_q) data_l_d = dm_dat_i;
        end else if (expired) begin
          state_d      = S_IDLE;
          load_done_d  = load_q;
          store_done_d = !load_q;
          err_d        = 1'b1;
          if (load_q) data_l_d = 32'h0;
        end else if ((state_q == S_STROBE) && !dm_stall_i) begin
          state_d = S_WAIT_ACK;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      load_q       <= 1'b0;
      we_q         <= 1'b0;
      adr_q        <= 32'h0;
      sel_q        <= 4'h0;
      dat_q        <= 32'h0;
      data_l_q     <= 32'h0;
      load_done_q  <= 1'b0;
      store_done_q <= 1'b0;
      misal_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      load_q       <= load_d;
      we_q         <= we_d;
      adr_q        <= adr_d;
      sel_q        <= sel_d;
      dat_q        <= dat_d;
      data_l_q     <= data_l_d;
      load_done_q  <= load_done_d;
      store_done_q <= store_done_d;
      misal_q      <= misal_d;
      err_q        <= err_d;
    end
  end

  assign dm_cyc_o        = (state_q != S_IDLE);
  assign dm_stb_o        = (state_q == S_STROBE);
  assign dm_we_o         = we_q;
  assign dm_adr_o        = adr_q;
  assign dm_sel_o        = sel_q;
  assign dm_dat_o        = dat_q;
  assign dm_data_l_o     = data_l_q;
  assign dm_load_done_o  = load_done_q;
  assign dm_store_done_o = store_done_q;
  assign dm_misaligned_o = misal_q;
  assign dm_bus_err_o    = err_q;

endmodule

// File: tb/tb_rv_dmem_lsu.sv
// Self-checking bench for rv_dmem_lsu: directed scenarios plus randomized
// transactions against a cycle-count reference model of the bus protocol.
module tb_rv_dmem_lsu;

  localparam int TIMEOUT = 16;
  localparam logic [2:0] F_B = 3'b000, F_H = 3'b001, F_L = 3'b010, F_BU = 3'b100, F_HU = 3'b101;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        x_valid_i, x_load_i, x_store_i;
  logic [2:0]  x_fun_i;
  logic [31:0] x_addr_i, x_store_data_i;
  logic        busy_o, dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_err_o;
  logic [31:0] dm_data_l_o;
  logic        dm_cyc_o, dm_stb_o, dm_we_o;
  logic [31:0] dm_adr_o, dm_dat_o, dm_dat_i;
  logic [3:0]  dm_sel_o;
  logic        dm_ack_i, dm_stall_i;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] exp_data_l = 32'h0;

  rv_dmem_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i),
    .x_valid_i(x_valid_i), .x_load_i(x_load_i), .x_store_i(x_store_i),
    .x_fun_i(x_fun_i), .x_addr_i(x_addr_i), .x_store_data_i(x_store_data_i),
    .busy_o(busy_o), .dm_load_done_o(dm_load_done_o), .dm_store_done_o(dm_store_done_o),
    .dm_data_l_o(dm_data_l_o), .dm_misaligned_o(dm_misaligned_o), .dm_bus_err_o(dm_bus_err_o),
    .dm_cyc_o(dm_cyc_o), .dm_stb_o(dm_stb_o), .dm_we_o(dm_we_o),
    .dm_adr_o(dm_adr_o), .dm_sel_o(dm_sel_o), .dm_dat_o(dm_dat_o),
    .dm_dat_i(dm_dat_i), .dm_ack_i(dm_ack_i), .dm_stall_i(dm_stall_i)
  );

  always #5 clk_i = ~clk_i;

  function automatic int width_of(input logic [2:0] fun);
    if (fun == F_B || fun == F_BU) return 1;
    if (fun == F_H || fun == F_HU) return 2;
    return 4;
  endfunction

  function automatic logic [6:0] status();
    return {dm_cyc_o, dm_stb_o, busy_o, dm_load_done_o, dm_store_done_o, dm_misaligned_o, dm_bus_err_o};
  endfunction

  // One full request from issue to done pulse. The slave holds stall for
  // stall_n cycles from the first strobe cycle and acks ack_dly cycles after
  // it takes the strobe (0 = same cycle).
  task automatic run_txn(input bit ld, input logic [2:0] fun, input logic [31:0] addr,
                         input logic [31:0] d, input int stall_n, input int ack_dly,
                         input logic [31:0] rdata, input string nm);
    int w, ack_c, done_c, lane;
    bit mis, to;
    logic [3:0]  e_sel;
    logic [31:0] e_dat;
    logic [6:0]  e_st, o_st;
    w     = width_of(fun);
    mis   = (addr % w) != 0;
    ack_c = mis ? -1 : stall_n + 1 + ack_dly;
    to    = !mis && (ack_c > TIMEOUT);
    done_c = mis ? 1 : (to ? TIMEOUT + 1 : ack_c + 1);
    e_sel = 4'b1111;
    e_dat = 32'h0;
    if (!ld) begin
      lane  = (addr % 4) / w * w;
      e_sel = 4'(((1 << w) - 1) << lane);
      for (int i = 0; i < 4; i++) e_dat[i*8 +: 8] = d[(i % w)*8 +: 8];
    end

    @(posedge clk_i); #1;
    tests_run++;
    if (busy_o !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s idle_before_issue: busy_o=%b required 0", nm, busy_o);
    end
    x_valid_i = 1'b1; x_load_i = ld; x_store_i = !ld;
    x_fun_i = fun; x_addr_i = addr; x_store_data_i = d;
    dm_stall_i = 1'b0; dm_ack_i = 1'b0;

    for (int c = 1; c <= done_c; c++) begin
      @(posedge clk_i); #1;
      x_valid_i = 1'b0; x_load_i = $urandom_range(0, 1); x_store_i = 1'b0;
      x_fun_i = 3'($urandom); x_addr_i = $urandom; x_store_data_i = $urandom;
      dm_stall_i = (c <= stall_n);
      dm_ack_i   = (c == ack_c);
      dm_dat_i   = (c == ack_c) ? rdata : $urandom;
      @(negedge clk_i);
      e_st = {!mis && c < done_c, !mis && c <= stall_n + 1 && c < done_c, 1'b1,
              c == done_c && ld, c == done_c && !ld, c == done_c && mis, c == done_c && to};
      o_st = status();
      tests_run++;
      if (o_st !== e_st) begin
        tests_failed++;
        $display("FAIL %s cycle%0d {cyc,stb,busy,ld,sd,mis,err}: got %b required %b", nm, c, o_st, e_st);
      end
      if (c == 1 && !mis) begin
        tests_run++;
        if ({dm_adr_o, dm_sel_o, dm_dat_o, dm_we_o} !== {addr & 32'hFFFF_FFFC, e_sel, e_dat, !ld}) begin
          tests_failed++;
          $display("FAIL %s bus_fields: adr=%h sel=%b dat=%h we=%b required adr=%h sel=%b dat=%h we=%b",
                   nm, dm_adr_o, dm_sel_o, dm_dat_o, dm_we_o, addr & 32'hFFFF_FFFC, e_sel, e_dat, !ld);
        end
      end
      if (c == done_c) begin
        if (ld && !mis) exp_data_l = to ? 32'h0 : rdata;
        tests_run++;
        if (dm_data_l_o !== exp_data_l) begin
          tests_failed++;
          $display("FAIL %s load_data: got %h required %h", nm, dm_data_l_o, exp_data_l);
        end
      end
    end
    dm_ack_i = 1'b0; dm_stall_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_n_i = 1'b0;
    x_valid_i = 0; x_load_i = 0; x_store_i = 0; x_fun_i = 0; x_addr_i = 0; x_store_data_i = 0;
    dm_dat_i = 32'h0; dm_ack_i = 0; dm_stall_i = 0;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if ({status(), dm_we_o, dm_adr_o, dm_sel_o, dm_dat_o, dm_data_l_o} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: status=%b adr=%h sel=%b dat=%h data_l=%h required all 0",
               status(), dm_adr_o, dm_sel_o, dm_dat_o, dm_data_l_o);
    end
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    exp_data_l = 32'h0;
  endtask

  task automatic test_directed();
    run_txn(1'b1, F_L,  32'h100, 32'h0,        0, 1,   32'hDEADBEEF, "lw_basic");
    run_txn(1'b0, F_B,  32'h203, 32'h000000A5, 0, 1,   32'h0,        "sb_lane3");
    run_txn(1'b0, F_H,  32'h202, 32'h00001234, 3, 1,   32'h0,        "sh_stall3");
    run_txn(1'b1, F_H,  32'h101, 32'h0,        0, 1,   32'h0,        "lh_misaligned");
    run_txn(1'b1, F_L,  32'h104, 32'h0,        0, 100, 32'h11111111, "lw_timeout");
    run_txn(1'b1, F_L,  32'h108, 32'h0,        0, 15,  32'hCAFEF00D, "lw_ack_at_expiry");
    run_txn(1'b0, F_L,  32'h10C, 32'h89ABCDEF, 0, 0,  32'h0,         "sw_same_cycle_ack");
  endtask

  task automatic test_ignored_inputs();
    // Stray ack while idle and a valid with neither load nor store.
    @(posedge clk_i); #1;
    dm_ack_i = 1'b1; dm_dat_i = 32'h5555AAAA;
    x_valid_i = 1'b1; x_load_i = 1'b0; x_store_i = 1'b0; x_addr_i = 32'h400;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if ({status(), dm_data_l_o} !== {7'b0, exp_data_l}) begin
      tests_failed++;
      $display("FAIL ignored_inputs: status=%b data_l=%h required 0000000 %h", status(), dm_data_l_o, exp_data_l);
    end
    dm_ack_i = 1'b0; x_valid_i = 1'b0;
  endtask

  task automatic test_reset_mid();
    @(posedge clk_i); #1;
    x_valid_i = 1'b1; x_load_i = 1'b1; x_store_i = 1'b0; x_fun_i = F_L; x_addr_i = 32'h300;
    @(posedge clk_i); #1 x_valid_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    tests_run++;
    if ({dm_cyc_o, dm_stb_o} !== 2'b10) begin
      tests_failed++;
      $display("FAIL rst_mid_wait_ack: cyc,stb=%b required 10", {dm_cyc_o, dm_stb_o});
    end
    #1 rst_n_i = 1'b0;
    #1;
    tests_run++;
    if (status() !== 7'b0) begin
      tests_failed++;
      $display("FAIL rst_mid_immediate: status=%b required 0000000", status());
    end
    @(posedge clk_i); #1 rst_n_i = 1'b1;
    exp_data_l = 32'h0;
    @(negedge clk_i);
    tests_run++;
    if ({status(), dm_data_l_o} !== 39'h0) begin
      tests_failed++;
      $display("FAIL rst_mid_no_done: status=%b data_l=%h required 0", status(), dm_data_l_o);
    end
    run_txn(1'b1, F_L, 32'h300, 32'h0, 0, 1, 32'h0BADC0DE, "lw_after_reset");
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, F_HU, 32'h500, 32'hFFFF8001, 0, 0, 32'h0,        "b2b_sh");
    run_txn(1'b1, F_BU, 32'h501, 32'h0,        1, 0, 32'h76543210, "b2b_lbu");
    run_txn(1'b0, F_L,  32'h502, 32'h12345678, 0, 1, 32'h0,        "b2b_sw_mis");
  endtask

  task automatic test_random();
    logic [2:0] funs [5];
    funs = '{F_B, F_H, F_L, F_BU, F_HU};
    for (int n = 0; n < 60; n++) begin
      int ad;
      ad = ($urandom_range(0, 15) == 0) ? 20 : $urandom_range(0, 3);
      run_txn(1'($urandom_range(0, 1)), funs[$urandom_range(0, 4)],
              $urandom & 32'h0000_FFFF, $urandom, $urandom_range(0, 3), ad, $urandom, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_ignored_inputs();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
